run_len_detector: RTL and testbench
===================================

Name: run_len_detector

Overview:
- Parametrised successor to the team's fixed 4-in-a-row serial detector.
- Watches a serial bit stream `w` and asserts `z` once a run of identical bits reaches a runtime-programmable length.
- Polarity is selectable: zeros, ones, either, or off.
- Counts qualifying runs; sits on serial-input front ends as a stuck-line / framing detector.

Parameters:
- RUN_W, 4, width of run counter and run_len config; max trackable run = 2^RUN_W-1.
- HIT_W, 16, width of qualifying-run counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  sample strobe; w is accepted only in cycles with en=1.
- w  input  1  serial data bit.
- run_len  input  RUN_W  required run length; 0 treated as 1; sampled every accepted cycle.
- mode  input  2  00 detect either polarity, 01 zeros only, 10 ones only, 11 detection disabled.
- clr  input  1  synchronous clear of run state and hit_cnt (not config).
- z  output  1  run-detected flag (registered, Moore-style).
- z_pol  output  1  polarity of current run (valid when z=1; 0 otherwise).
- run_cnt  output  RUN_W  length of current run, saturating.
- hit_cnt  output  HIT_W  number of runs that reached threshold, saturating.

Behaviour:
- Interface: one clock domain, `clk`; reset is `reset`, synchronous, active-high.
- Reset (and clr) values: state=ST_IDLE, run_cnt=0, z=0, z_pol=0, hit_cnt=0.
- FSM states: ST_IDLE (no sample yet), ST_RUN0 (current run of 0s), ST_RUN1 (current run of 1s).
- Transitions occur only on accepted samples (en=1 and not reset/clr):
  - IDLE: w=0 -> RUN0, run_cnt=1; w=1 -> RUN1, run_cnt=1.
  - RUN0: w=0 -> stay, run_cnt+1 saturating at 2^RUN_W-1; w=1 -> RUN1, run_cnt=1.
  - RUN1: symmetric.
  - en=0: all state, run_cnt and z hold.
- Threshold: eff_len = (run_len==0) ? 1 : run_len.
- qual = (next run_cnt >= eff_len) && polarity permitted by mode (mode 11 never permits).
- z <= qual; z_pol <= qual ? next polarity : 0.
- Latency: sample accepted in cycle t -> z valid from cycle t+1. z stays high while the run continues, including after run_cnt saturates.
- Polarity change mid-run: run_cnt restarts at 1; z drops the next cycle unless eff_len==1 and the new polarity is permitted. In that case z stays 1 and z_pol flips.
- Runtime changes to mode or run_len: take effect on the next accepted sample only; z does not change in cycles with en=0.
- hit_cnt increments by 1 on each accepted sample where qual=1 and z (registered) was 0, or where z_pol flips while qual=1. Exactly one count per qualifying run. Saturates at all-ones; no wrap.
- Simultaneous events: reset has priority over clr, which has priority over en. clr with en=1 discards that sample.
- Reset mid-run: all outputs return to reset values the next cycle; no hit is counted.

Optional Feature:
- Macro RUN_LEN_DET_HIT_CNT_EN.
- Defined: hit counter implemented as above.
- Undefined: no counter flops; hit_cnt tied to 0; all other behaviour identical.

Decomposition:
- Package run_len_det_pkg:
  - state_e {ST_IDLE, ST_RUN0, ST_RUN1}.
  - mode_e {MODE_ANY=2'b00, MODE_ZERO=2'b01, MODE_ONE=2'b10, MODE_OFF=2'b11}.
- Sub-module sat_counter (parameter W; inputs inc, load1, clr; output cnt, saturating). Instantiated for run_cnt, and for hit_cnt under the macro.

Test Plan:
- reset=1 for 2 cycles, then en=1, mode=00, run_len=4, w=0,0,0,0,0,1 -> z=0 for first 3 samples; z=1,z_pol=0 the cycle after the 4th 0 and after the 5th; z=0 after the 1; hit_cnt=1.
- mode=10, run_len=3, w=0x6 then 1x3 -> z never high during the zeros; z=1,z_pol=1 after the 3rd 1; hit_cnt=1.
- RUN_W=4, run_len=15, w=1 for 20 samples -> run_cnt saturates at 15; z=1 from the 15th sample through the 20th; hit_cnt=1.
- run_len=0, mode=00, alternating w=0,1,0,1 -> z=1 every cycle; z_pol tracks w; hit_cnt=4.
- run_len=2, w=1,1 with en low between samples -> z=1 only after the 2nd accepted 1; holds through the gaps; assert clr -> all outputs 0 next cycle.
- Assert reset mid-run at run_cnt=3 with z=1 -> next cycle z=0, run_cnt=0, hit_cnt=0. Build without RUN_LEN_DET_HIT_CNT_EN -> hit_cnt stays 0 in all above.

Source files
------------

// File: rtl/run_len_det_pkg.sv
// Shared types and helpers for the run-length detector.
package run_len_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN0 = 2'b01,
    ST_RUN1 = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_ANY  = 2'b00,
    MODE_ZERO = 2'b01,
    MODE_ONE  = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  // True when a run of polarity pol may raise the detect flag under mode m.
  function automatic logic pol_permitted(input mode_e m, input logic pol);
    case (m)
      MODE_ANY:  return 1'b1;
      MODE_ZERO: return ~pol;
      MODE_ONE:  return pol;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
// Priority: clr over load1 over inc; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = W'(1);
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/run_len_detector.sv
// Serial run-length detector: flags runs of identical bits reaching run_len.
// Qualifying-run counter built only when RUN_LEN_DET_HIT_CNT_EN is defined.
module run_len_detector
  import run_len_det_pkg::*;
#(
  parameter int unsigned RUN_W = 4,
  parameter int unsigned HIT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  input  logic [RUN_W-1:0] run_len,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             z,
  output logic             z_pol,
  output logic [RUN_W-1:0] run_cnt,
  output logic [HIT_W-1:0] hit_cnt
);

  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  state_e           state_q, state_d;
  logic             z_q, z_d;
  logic             z_pol_q, z_pol_d;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_nxt;
  logic [RUN_W-1:0] eff_len;
  logic             same_run;
  logic             qual;
  logic             run_load1;
  logic             run_inc;
  logic             wipe;

  assign wipe = reset | clr;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      z_q     <= 1'b0;
      z_pol_q <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      z_pol_q <= z_pol_d;
    end
  end

  // Next state: an accepted sample always lands in the run of its own polarity
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else if (en) begin
      state_d = w ? ST_RUN1 : ST_RUN0;
    end
  end

  // Outputs and counter controls
  always_comb begin
    same_run  = ((state_q == ST_RUN1) && w) || ((state_q == ST_RUN0) && !w);
    run_nxt   = !same_run ? RUN_W'(1)
              : (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    eff_len   = (run_len == '0) ? RUN_W'(1) : run_len;
    qual      = (run_nxt >= eff_len) && pol_permitted(mode_e'(mode), w);
    z_d       = z_q;
    z_pol_d   = z_pol_q;
    run_load1 = 1'b0;
    run_inc   = 1'b0;
    if (clr) begin
      z_d     = 1'b0;
      z_pol_d = 1'b0;
    end else if (en) begin
      z_d       = qual;
      z_pol_d   = qual & w;
      run_load1 = ~same_run;
      run_inc   = same_run;
    end
  end

  sat_counter #(.W(RUN_W)) u_run_cnt (
    .clk   (clk),
    .clr   (wipe),
    .load1 (run_load1),
    .inc   (run_inc),
    .cnt   (run_q)
  );

`ifdef RUN_LEN_DET_HIT_CNT_EN
  logic hit_inc;

  // A new run qualifies, or a qualifying run flips polarity at eff_len==1
  assign hit_inc = en & ~wipe & qual & (~z_q | (z_pol_q != w));

  sat_counter #(.W(HIT_W)) u_hit_cnt (
    .clk   (clk),
    .clr   (wipe),
    .load1 (1'b0),
    .inc   (hit_inc),
    .cnt   (hit_cnt)
  );
`else
  assign hit_cnt = '0;
`endif

  assign z       = z_q;
  assign z_pol   = z_pol_q;
  assign run_cnt = run_q;

endmodule

// File: tb/tb_run_len_detector.sv
// Self-checking bench for run_len_detector: behavioural run model plus literal pins.
module tb_run_len_detector;

  localparam int RUN_MAX = 15;
  localparam int HIT_MAX = 65535;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        w = 1'b0;
  logic [3:0]  run_len = 4'd4;
  logic [1:0]  mode = 2'b00;
  logic        clr = 1'b0;
  logic        z;
  logic        z_pol;
  logic [3:0]  run_cnt;
  logic [15:0] hit_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: length of the current run of equal accepted bits
  bit m_have = 0;
  bit m_prev = 0;
  int m_len  = 0;
  bit m_z    = 0;
  bit m_pol  = 0;
  int m_hits = 0;

  run_len_detector #(.RUN_W(4), .HIT_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .w       (w),
    .run_len (run_len),
    .mode    (mode),
    .clr     (clr),
    .z       (z),
    .z_pol   (z_pol),
    .run_cnt (run_cnt),
    .hit_cnt (hit_cnt)
  );

  always #5 clk = ~clk;

  function automatic int hit_lit(input int n);
`ifdef RUN_LEN_DET_HIT_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model, updated on each rising edge from the applied inputs
  always @(posedge clk) begin
    bit allowed;
    int need;
    bit q;
    if (reset || clr) begin
      m_have = 0; m_len = 0; m_z = 0; m_pol = 0; m_hits = 0;
    end else if (en) begin
      if (m_have && (w == m_prev)) m_len = (m_len < RUN_MAX) ? m_len + 1 : RUN_MAX;
      else m_len = 1;
      m_have  = 1;
      m_prev  = w;
      need    = (run_len == 0) ? 1 : int'(run_len);
      allowed = (mode == 2'b00) || (mode == 2'b01 && !w) || (mode == 2'b10 && w);
      q       = (m_len >= need) && allowed;
      if (q && (!m_z || (m_pol != w)) && m_hits < HIT_MAX) m_hits++;
      m_z   = q;
      m_pol = q ? w : 1'b0;
    end
  end

  // Compare process: outputs are stable at the falling edge
  always @(negedge clk) begin
    check("z", int'(z), int'(m_z));
    check("z_pol", int'(z_pol), int'(m_pol));
    check("run_cnt", int'(run_cnt), m_len);
    check("hit_cnt", int'(hit_cnt), hit_lit(m_hits));
  end

  task automatic step(input logic e, input logic wv);
    en = e;
    w  = wv;
    @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    en  = 1'b1;
    w   = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    en  = 1'b0;
  endtask

  initial begin
    step(0, 0);
    step(0, 0);
    reset = 1'b0;
    check("rst_z", int'(z), 0);
    check("rst_run_cnt", int'(run_cnt), 0);
    check("rst_hit_cnt", int'(hit_cnt), 0);

    // Run of zeros, run_len=4, either polarity
    mode = 2'b00; run_len = 4'd4;
    repeat (3) step(1, 0);
    check("t1_z_before", int'(z), 0);
    check("t1_cnt3", int'(run_cnt), 3);
    step(1, 0);
    check("t1_z_at4", int'(z), 1);
    check("t1_pol_at4", int'(z_pol), 0);
    step(1, 0);
    check("t1_z_at5", int'(z), 1);
    step(1, 1);
    check("t1_z_drop", int'(z), 0);
    check("t1_cnt_restart", int'(run_cnt), 1);
    check("t1_hits", int'(hit_cnt), hit_lit(1));

    // Ones only
    do_clr();
    mode = 2'b10; run_len = 4'd3;
    repeat (6) step(1, 0);
    check("t2_zeros_ignored", int'(z), 0);
    repeat (3) step(1, 1);
    check("t2_z", int'(z), 1);
    check("t2_pol", int'(z_pol), 1);
    check("t2_hits", int'(hit_cnt), hit_lit(1));

    // Saturation at 15
    do_clr();
    mode = 2'b00; run_len = 4'd15;
    repeat (14) step(1, 1);
    check("t3_z_at14", int'(z), 0);
    step(1, 1);
    check("t3_z_at15", int'(z), 1);
    check("t3_cnt15", int'(run_cnt), 15);
    repeat (5) step(1, 1);
    check("t3_z_at20", int'(z), 1);
    check("t3_cnt_sat", int'(run_cnt), 15);
    check("t3_hits", int'(hit_cnt), hit_lit(1));

    // run_len=0 acts as 1 with alternating input
    do_clr();
    run_len = 4'd0;
    step(1, 0); check("t4_pol0", int'(z_pol), 0); check("t4_z0", int'(z), 1);
    step(1, 1); check("t4_pol1", int'(z_pol), 1); check("t4_z1", int'(z), 1);
    step(1, 0); check("t4_pol2", int'(z_pol), 0);
    step(1, 1); check("t4_pol3", int'(z_pol), 1);
    check("t4_hits", int'(hit_cnt), hit_lit(4));

    // Gaps with en low; config change during gap has no effect
    do_clr();
    run_len = 4'd2;
    step(1, 1);
    step(0, 0);
    check("t5_gap_z", int'(z), 0);
    step(1, 1);
    check("t5_z", int'(z), 1);
    run_len = 4'd15; mode = 2'b11;
    step(0, 0);
    step(0, 1);
    check("t5_hold", int'(z), 1);
    check("t5_hold_cnt", int'(run_cnt), 2);
    do_clr();
    check("t5_clr_z", int'(z), 0);
    check("t5_clr_cnt", int'(run_cnt), 0);
    check("t5_clr_hits", int'(hit_cnt), 0);

    // Detection disabled
    mode = 2'b11; run_len = 4'd1;
    repeat (5) step(1, 1);
    check("t6_off", int'(z), 0);

    // Reset mid-run
    mode = 2'b00; run_len = 4'd2;
    do_clr();
    repeat (3) step(1, 0);
    check("t7_pre_z", int'(z), 1);
    check("t7_pre_cnt", int'(run_cnt), 3);
    reset = 1'b1;
    step(1, 0);
    reset = 1'b0;
    check("t7_rst_z", int'(z), 0);
    check("t7_rst_cnt", int'(run_cnt), 0);
    check("t7_rst_hits", int'(hit_cnt), 0);

    // Pseudo-random sweep checked by the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) run_len = 4'($urandom_range(0, 6));
      clr = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) w = ~w;
      @(negedge clk);
      clr = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
